pcie_trans_tx: RTL

// - Transmit side of the transaction layer: merges two source streams (port 0, port 1) into the single

---
 rtl/pcie_trans_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pcie_trans_tx.sv
// pcie_trans_tx: merges two buffered source ports into one output stream.
// A round-robin arbiter with a burst limit drains the two port FIFOs.
module pcie_trans_tx_fifo #(
    parameter int W = 6,
    parameter int L = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W-1:0]             data,
    input  logic                     push,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(L+1)-1:0]   count,
    output logic                     wr_error
);
    localparam int PW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = $clog2(L + 1);
    localparam logic [PW-1:0] LAST = PW'(L - 1);
    localparam logic [CW-1:0] FULL = CW'(L);

    logic [W-1:0]  mem [L];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          wr;

    assign full = (count == FULL);
    assign wr   = push && !full;
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_error <= 1'b0;
        end else begin
            if (wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(wr) - CW'(pop);
            // a push into a full FIFO is an error even if a pop frees space
            if (push && full) wr_error <= 1'b1;
        end
    end
endmodule

module pcie_trans_tx #(
    parameter int BITNUMBER = 6,
    parameter int LENGTH    = 4,
    parameter int BURST     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITNUMBER-1:0] data_in0,
    input  logic                 push0,
    input  logic [BITNUMBER-1:0] data_in1,
    input  logic                 push1,
    input  logic                 tx_pause,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    output logic                 pause0,
    output logic                 pause1,
    output logic                 wr_error0,
    output logic                 wr_error1
);
    localparam int CW = $clog2(LENGTH + 1);
    localparam int BW = $clog2(BURST + 2);
    localparam logic [CW-1:0] ALMOST = CW'(LENGTH - 1);
    localparam logic [BW-1:0] BLIM   = BW'(BURST);

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    state_t               state;
    logic [BW-1:0]        burst_cnt;
    logic [BW-1:0]        cnt_inc;
    logic                 last_grant;
    logic [BITNUMBER-1:0] head0;
    logic [BITNUMBER-1:0] head1;
    logic [CW-1:0]        count0;
    logic [CW-1:0]        count1;
    logic                 ne0;
    logic                 ne1;
    logic                 pop0;
    logic                 pop1;

    pcie_trans_tx_fifo #(.W(BITNUMBER), .L(LENGTH)) u_fifo0 (
        .clk(clk), .reset(reset), .data(data_in0), .push(push0),
        .pop(pop0), .head(head0), .count(count0), .wr_error(wr_error0)
    );

    pcie_trans_tx_fifo #(.W(BITNUMBER), .L(LENGTH)) u_fifo1 (
        .clk(clk), .reset(reset), .data(data_in1), .push(push1),
        .pop(pop1), .head(head1), .count(count1), .wr_error(wr_error1)
    );

    assign ne0     = (count0 != '0);
    assign ne1     = (count1 != '0);
    assign pause0  = (count0 >= ALMOST);
    assign pause1  = (count1 >= ALMOST);
    assign cnt_inc = burst_cnt + BW'(1);

    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (!tx_pause) begin
            unique case (state)
                IDLE: begin
                    if (ne0 && ne1) begin
                        pop0 = last_grant;
                        pop1 = !last_grant;
                    end else begin
                        pop0 = ne0;
                        pop1 = ne1;
                    end
                end
                SERVE0:  pop0 = ne0;
                SERVE1:  pop1 = ne1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_grant <= 1'b1;
            data_out   <= '0;
            valid_out  <= 1'b0;
        end else begin
            valid_out <= pop0 || pop1;
            if (pop0) data_out <= head0;
            else if (pop1) data_out <= head1;
            if (pop0 || pop1) last_grant <= pop1;
            unique case (state)
                IDLE: begin
                    if (pop0 || pop1) begin
                        state     <= pop0 ? SERVE0 : SERVE1;
                        burst_cnt <= BW'(1);
                    end
                end
                SERVE0: begin
                    if (!tx_pause) begin
                        if (ne0) begin
                            if (cnt_inc >= BLIM) begin
                                burst_cnt <= '0;
                                if (ne1) state <= SERVE1;
                            end else begin
                                burst_cnt <= cnt_inc;
                            end
                        end else begin
                            burst_cnt <= '0;
                            state     <= ne1 ? SERVE1 : IDLE;
                        end
                    end
                end
                SERVE1: begin
                    if (!tx_pause) begin
                        if (ne1) begin
                            if (cnt_inc >= BLIM) begin
                                burst_cnt <= '0;
                                if (ne0) state <= SERVE0;
                            end else begin
                                burst_cnt <= cnt_inc;
                            end
                        end else begin
                            burst_cnt <= '0;
                            state     <= ne0 ? SERVE0 : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
